// File: rtl/iir_pkg.sv
// Shared constants, default feedback coefficients and FSM encoding
// for the IIR filter chain (zero and pole sections).
package iir_pkg;

  localparam int COE_FRAC = 9;
  localparam int ZIN_W    = 21;
  localparam int Y_W      = 12;
  localparam int ACC_W    = 28;
  localparam int PROD_W   = 2 * Y_W;

  localparam logic signed [Y_W-1:0] A_COE [1:7] = '{
    -12'sd300,
     12'sd120,
    -12'sd40,
     12'sd20,
    -12'sd10,
     12'sd5,
    -12'sd2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_e;

endpackage

// File: rtl/iir_round_sat.sv
// Round-half-up by 2^FRAC, then clip to a signed OUT_W result.
// Used wherever the IIR chain narrows its datapath.
module iir_round_sat
  import iir_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = Y_W,
  parameter int FRAC  = COE_FRAC
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    sat_o
);

  localparam logic signed [IN_W-1:0] HALF =
    {{(IN_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [IN_W-1:0] YMAX =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] YMIN =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] sum;
  logic signed [IN_W-1:0] r;
  logic                   hi;
  logic                   lo;

  always_comb begin
    sum = acc_i + HALF;
    r   = sum >>> FRAC;
    hi  = (r > YMAX);
    lo  = (r < YMIN);
    y_o = r[OUT_W-1:0];
    if (hi) y_o = {1'b0, {(OUT_W-1){1'b1}}};
    if (lo) y_o = {1'b1, {(OUT_W-1){1'b0}}};
    sat_o = hi | lo;
  end

endmodule

// File: rtl/iir_pole_serial.sv
// Recursive pole section: y = (z - sum a_k*y(n-k)) / 2^COE_FRAC,
// one shared multiplier, seven MAC cycles per sample.
module iir_pole_serial
  import iir_pkg::*;
#(
  parameter logic signed [Y_W-1:0] A1 = A_COE[1],
  parameter logic signed [Y_W-1:0] A2 = A_COE[2],
  parameter logic signed [Y_W-1:0] A3 = A_COE[3],
  parameter logic signed [Y_W-1:0] A4 = A_COE[4],
  parameter logic signed [Y_W-1:0] A5 = A_COE[5],
  parameter logic signed [Y_W-1:0] A6 = A_COE[6],
  parameter logic signed [Y_W-1:0] A7 = A_COE[7]
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ZIN_W-1:0] zin,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [Y_W-1:0]   yout,
  output logic                    out_valid,
  output logic                    sat
);

  state_e                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [Y_W-1:0]   yh_q [1:7];
  logic signed [Y_W-1:0]   yout_q;
  logic                    sat_q;
  logic                    vld_q;

  logic signed [Y_W-1:0]    coe;
  logic signed [Y_W-1:0]    ysel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  zin_x;
  logic signed [Y_W-1:0]    y_rs;
  logic                     sat_rs;

  always_comb begin
    coe  = '0;
    ysel = '0;
    unique case (k_q)
      3'd1: begin coe = A1; ysel = yh_q[1]; end
      3'd2: begin coe = A2; ysel = yh_q[2]; end
      3'd3: begin coe = A3; ysel = yh_q[3]; end
      3'd4: begin coe = A4; ysel = yh_q[4]; end
      3'd5: begin coe = A5; ysel = yh_q[5]; end
      3'd6: begin coe = A6; ysel = yh_q[6]; end
      3'd7: begin coe = A7; ysel = yh_q[7]; end
      default: ;
    endcase
  end

  assign prod =
    $signed({{Y_W{coe[Y_W-1]}}, coe}) *
    $signed({{Y_W{ysel[Y_W-1]}}, ysel});
  assign prod_x =
    $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  assign zin_x =
    $signed({{(ACC_W-ZIN_W){zin[ZIN_W-1]}}, zin});

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MAC;
          k_d     = 3'd1;
          acc_d   = zin_x;
        end
      end
      MAC: begin
        acc_d = acc_q - prod_x;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd7) state_d = ROUND;
      end
      ROUND: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  iir_round_sat u_rs (
    .acc_i (acc_q),
    .y_o   (y_rs),
    .sat_o (sat_rs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      yout_q  <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
      for (int i = 1; i <= 7; i++) yh_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      vld_q   <= (state_q == ROUND);
      // history keeps the clipped sample so feedback matches the output
      if (state_q == ROUND) begin
        yout_q  <= y_rs;
        sat_q   <= sat_rs;
        yh_q[1] <= y_rs;
        for (int i = 2; i <= 7; i++) yh_q[i] <= yh_q[i-1];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign yout      = yout_q;
  assign sat       = sat_q;
  assign out_valid = vld_q;

endmodule
